// File: rtl/bloom_filter_mk.sv
// K-probe Bloom filter over a 32-bit-word bit array: query/insert requests, double-hashed probes,
// serial read-modify-write per probe, and a word-per-cycle clear sweep on reset or request.
module bloom_filter_mk #(
    parameter int          KEY_W  = 72,
    parameter int          M_LOG2 = 10,
    parameter int          K      = 3,
    parameter logic [31:0] SEED   = 32'hdeadbef8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    input  logic             in_op,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic             out_op,
    output logic [15:0]      n_inserts,
    output logic [2:0]       state_dbg
);

    localparam int D  = 2 ** (M_LOG2 - 5);
    localparam int AW = (M_LOG2 > 5) ? (M_LOG2 - 5) : 1;
    localparam int PW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_HASH  = 3'd2,
        S_PRD   = 3'd3,
        S_PCHK  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            state;
    logic [31:0]       a, b, c;
    logic [31:0]       a_n, b_n, c_n;
    logic [2:0]        step;
    logic [PW-1:0]     probe;
    logic [M_LOG2-1:0] idx, h2;
    logic              op, hit, clr_pend;
    logic [AW-1:0]     clr_cnt;
    logic [95:0]       key96;

    logic [31:0]       mem [D];
    logic [31:0]       rdata;
    logic [AW-1:0]     wa;
    logic [4:0]        bit_sel;
    logic              probe_bit;
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [31:0]       mem_wd;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Handshakes: a request transfers on a cycle with in_valid && in_ready; a response transfers on a
    // cycle with out_valid && out_ready. out_valid/out_hit/out_op hold steady until that transfer.
    assign in_ready  = (state == S_IDLE) && !clr_pend && !clear_req;
    assign state_dbg = state;

    always_comb begin
        key96 = '0;
        key96[KEY_W-1:0] = in_key;
    end

    always_comb begin
        a_n = a;
        b_n = b;
        c_n = c;
        case (step)
            3'd0:    c_n = (c ^ b) - rol(b, 14);
            3'd1:    a_n = (a ^ c) - rol(c, 11);
            3'd2:    b_n = (b ^ a) - rol(a, 25);
            3'd3:    a_n = (a ^ c) - rol(c, 4);
            3'd4:    b_n = (b ^ a) - rol(a, 14);
            3'd5:    c_n = (c ^ b) - rol(b, 24);
            default: ;
        endcase
    end

    generate
        if (M_LOG2 > 5) begin : g_wa
            assign wa = idx[M_LOG2-1:5];
        end else begin : g_wa_single
            assign wa = '0;
        end
    endgenerate

    assign bit_sel   = idx[4:0];
    assign probe_bit = rdata[bit_sel];

    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = rdata | (32'd1 << bit_sel);
        if (state == S_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt;
            mem_wd = '0;
        end else if (state == S_PCHK && op) begin
            mem_we = 1'b1;
        end
        if (reset) mem_we = 1'b0;
    end

    // Single-ported array: the only read is issued from PRD, writes come from CLEAR and PCHK.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (state == S_PRD) rdata <= mem[wa];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
            clr_pend   <= 1'b0;
            out_valid  <= 1'b0;
            out_hit    <= 1'b0;
            out_op     <= 1'b0;
            n_inserts  <= '0;
            step       <= '0;
            probe      <= '0;
            op         <= 1'b0;
            hit        <= 1'b0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            idx        <= '0;
            h2         <= '0;
        end else begin
            if (clear_req && state != S_IDLE) clr_pend <= 1'b1;
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(D - 1)) begin
                        state      <= S_IDLE;
                        clear_busy <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (clear_req || clr_pend) begin
                        state      <= S_CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                        clr_pend   <= 1'b0;
                    end else if (in_valid) begin
                        a     <= SEED + key96[95:64];
                        b     <= SEED + key96[63:32];
                        c     <= SEED + key96[31:0];
                        op    <= in_op;
                        hit   <= 1'b1;
                        step  <= '0;
                        state <= S_HASH;
                    end
                end
                S_HASH: begin
                    a    <= a_n;
                    b    <= b_n;
                    c    <= c_n;
                    step <= step + 3'd1;
                    if (step == 3'd5) begin
                        // Only the low M_LOG2 bits of h1 + i*h2 matter, so the running index wraps there.
                        idx   <= c_n[M_LOG2-1:0];
                        h2    <= b_n[M_LOG2-1:0] | M_LOG2'(1);
                        probe <= '0;
                        state <= S_PRD;
                    end
                end
                S_PRD: state <= S_PCHK;
                S_PCHK: begin
                    hit <= hit & probe_bit;
                    idx <= idx + h2;
                    if (probe == PW'(K - 1)) begin
                        out_valid <= 1'b1;
                        out_hit   <= hit & probe_bit;
                        out_op    <= op;
                        state     <= S_RESP;
                    end else begin
                        probe <= probe + 1'b1;
                        state <= S_PRD;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                        if (out_op && !out_hit && n_inserts != 16'hffff)
                            n_inserts <= n_inserts + 16'd1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_bloom_filter_mk.sv
// Randomized bench for bloom_filter_mk: a bit-array reference model predicts each response into a
// queue and a negedge monitor compares every response, its latency and its hold stability.
module tb_bloom_filter_mk;

    localparam int          KEY_W  = 72;
    localparam int          M_LOG2 = 10;
    localparam int          K      = 3;
    localparam logic [31:0] SEED   = 32'hdeadbef8;
    localparam int          MBITS  = 2 ** M_LOG2;
    localparam int          LAT    = 7 + 2 * K;
    localparam int          SWEEP  = MBITS / 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [KEY_W-1:0] in_key = '0;
    logic             in_op = 1'b0;
    logic             clear_req = 1'b0;
    logic             clear_busy;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_hit;
    logic             out_op;
    logic [15:0]      n_inserts;
    logic [2:0]       state_dbg;

    bloom_filter_mk #(.KEY_W(KEY_W), .M_LOG2(M_LOG2), .K(K), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_op(in_op), .clear_req(clear_req), .clear_busy(clear_busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_hit(out_hit), .out_op(out_op), .n_inserts(n_inserts),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- checking helpers and reference model ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    bit          model_bits [MBITS];
    logic [15:0] model_n = '0;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic void model_clear();
        foreach (model_bits[i]) model_bits[i] = 1'b0;
    endfunction

    // Hash the key as described, then test (and for insert, set) each probe bit in probe order.
    function automatic bit model_access(input logic [KEY_W-1:0] key, input bit ins);
        logic [95:0] k96;
        logic [31:0] a, b, c, h1, h2, ix;
        bit          hit;
        k96 = {24'd0, key};
        a = SEED + k96[95:64];
        b = SEED + k96[63:32];
        c = SEED + k96[31:0];
        c = (c ^ b) - rotl(b, 14);
        a = (a ^ c) - rotl(c, 11);
        b = (b ^ a) - rotl(a, 25);
        a = (a ^ c) - rotl(c, 4);
        b = (b ^ a) - rotl(a, 14);
        c = (c ^ b) - rotl(b, 24);
        h1 = c;
        h2 = b | 32'd1;
        hit = 1'b1;
        for (int i = 0; i < K; i++) begin
            ix = (h1 + 32'(i) * h2) % MBITS;
            hit = hit & model_bits[ix[M_LOG2-1:0]];
            if (ins) model_bits[ix[M_LOG2-1:0]] = 1'b1;
        end
        return hit;
    endfunction

    // Expected entry: [49]=op, [48]=hit, [47:32]=n_inserts seen at the response, [31:0]=accept cycle.
    logic [49:0] exp_q[$];

    // ---------------- monitor ----------------
    logic ov_prev = 1'b0, hit_prev = 1'b0, op_prev = 1'b0;

    always @(negedge clk) begin
        logic [49:0] e;
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                else chk("latency", cyc, exp_q[0][31:0] + LAT);
            end
            if (out_valid && ov_prev) begin
                chk("hold_out_hit", 32'(out_hit), 32'(hit_prev));
                chk("hold_out_op", 32'(out_op), 32'(op_prev));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_op", 32'(out_op), 32'(e[49]));
                chk("out_hit", 32'(out_hit), 32'(e[48]));
                chk("n_inserts_at_resp", 32'(n_inserts), 32'(e[47:32]));
            end
            ov_prev  = out_valid;
            hit_prev = out_hit;
            op_prev  = out_op;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input logic [KEY_W-1:0] key, output int t);
        int n;
        bit hit;
        in_valid = 1'b1;
        in_key   = key;
        in_op    = op;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        t = cyc;
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        hit = model_access(key, op);
        exp_q.push_back({op, hit, model_n, 32'(t)});
        if (op && !hit && model_n != 16'hffff) model_n = model_n + 16'd1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        if (!rnd) out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 300) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (exp_q.size() > 0) begin
            chk("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic sweep_count(input string name);
        int n;
        n = 0;
        while (clear_busy && n < 200) begin
            chk({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, SWEEP);
        chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_clear_done();
        int n;
        n = 0;
        while (!clear_busy && n < 5) begin
            tick();
            n++;
        end
        chk("clear_busy_rise", 32'(clear_busy), 32'd1);
        n = 0;
        while (clear_busy && n < 200) begin
            tick();
            n++;
        end
        chk("clear_busy_fall", 32'(clear_busy), 32'd0);
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        model_clear();
        wait_clear_done();
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] k;
        k[31:0]  = $urandom();
        k[63:32] = $urandom();
        k[71:64] = 8'($urandom());
        return k;
    endfunction

    // ---------------- test sequence ----------------
    localparam logic [KEY_W-1:0] KEY0 = 72'h0123456789abcdef01;

    initial begin
        int t;
        logic [KEY_W-1:0] key1, key2, k;
        logic [KEY_W-1:0] pool [8];
        model_clear();
        foreach (pool[i]) pool[i] = rand_key();
        key1 = rand_key();
        key2 = rand_key();

        repeat (3) tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_clear_busy", 32'(clear_busy), 32'd1);
        chk("reset_out_hit", 32'(out_hit), 32'd0);
        chk("reset_out_op", 32'(out_op), 32'd0);
        chk("reset_n_inserts", 32'(n_inserts), 32'd0);
        reset = 1'b0;
        sweep_count("init_sweep");

        // Directed query / insert / query / reinsert of a fixed key.
        send(1'b0, KEY0, t); wait_done(1'b0);
        send(1'b1, KEY0, t); wait_done(1'b0);
        chk("n_inserts_first_insert", 32'(n_inserts), 32'd1);
        send(1'b0, KEY0, t); wait_done(1'b0);
        send(1'b1, KEY0, t); wait_done(1'b0);
        chk("n_inserts_reinsert", 32'(n_inserts), 32'd1);

        // Response held for 5 cycles with a competing request presented.
        out_ready = 1'b0;
        send(1'b0, KEY0, t);
        for (int n = 0; n < 50 && !out_valid; n++) tick();
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_key   = rand_key();
            in_op    = 1'b1;
            tick();
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        wait_done(1'b0);

        // Randomized traffic with reuse of a small key pool, random backpressure and random clears.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_clear();
            end else begin
                k = ($urandom_range(0, 3) == 0) ? rand_key() : pool[$urandom_range(0, 7)];
                send(1'($urandom_range(0, 1)), k, t);
                wait_done(1'b1);
            end
        end
        chk("n_inserts_after_random", 32'(n_inserts), 32'(model_n));

        // Clear requested mid-insert: insert finishes, sweep follows, key is gone.
        send(1'b1, key1, t);
        while (cyc < t + 4) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        model_clear();
        wait_done(1'b0);
        chk("pending_clear_in_ready", 32'(in_ready), 32'd0);
        wait_clear_done();
        send(1'b0, key1, t); wait_done(1'b0);

        // Reset mid-insert: no response, fresh sweep, empty array, counter zeroed.
        send(1'b1, KEY0, t); wait_done(1'b0);
        send(1'b1, key2, t);
        while (cyc < t + 9) tick();
        reset = 1'b1;
        exp_q.delete();
        model_clear();
        model_n = '0;
        tick();
        reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_clear_busy", 32'(clear_busy), 32'd1);
        sweep_count("abort_sweep");
        chk("abort_n_inserts", 32'(n_inserts), 32'd0);
        send(1'b0, KEY0, t); wait_done(1'b0);
        send(1'b0, key2, t); wait_done(1'b0);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, pool[i], t);
            wait_done(1'b0);
        end

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
